alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Multi-cycle control FSM that sequences the shared 32-bit ALU and the single unified memory port of the processor datapath. Per instruction it steps through fetch, decode, execute, memory and write-back. It drives the 3-bit ALU opcode and all datapath write strobes and mux selects. It also consumes the ALU's `change_pc` flag to resolve branches.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `instr` input 32: current memory read data; only `instr[31:29]` (major opcode) is used, sampled on the IR load edge.
- `mem_ready` input 1: memory handshake acknowledge; ignored while `mem_req`=0.
- `change_pc` input 1: ALU branch-taken flag; valid in EXEC.
- `mem_req` output 1: memory access request.
- `mem_we` output 1: memory write enable; qualifies `mem_req`.
- `mem_addr_sel` output 1: address mux select; 0=PC, 1=ALUOut.
- `ir_write` output 1: load IR from memory data.
- `pc_write` output 1: PC load enable.
- `pc_src` output 1: PC source select; 0=PC+1, 1=branch target.
- `alu_opcode` output 3: ALU operation code.
- `alu_src_b` output 1: ALU B-input select; 0=register, 1=sign-extended immediate.
- `alu_out_we` output 1: latch ALU result into ALUOut.
- `reg_write` output 1: register-file write enable.
- `wb_sel` output 1: write-back source select; 0=ALUOut, 1=memory data.
- `instr_done` output 1: one-cycle pulse marking instruction retirement.
- `state` output 3: current FSM state, for debug.
- `instr_count` output 32: number of retired instructions.

## Operation
- Major opcodes:
  - 0 = LW, 1 = SW, 2 = BEQ, 3 = BLT, 4 = ADD, 5 = SUB, 6 = AND, 7 = OR.
  - ALU opcode equals the major opcode for codes 2–7.
  - LW and SW use ALU opcode 4 (ADD) for address generation.
- `op_q` (3-bit register) latches `instr[31:29]` on the FETCH completion edge. All later decoding uses `op_q`.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Encodings 5–7 are illegal and go to FETCH on the next edge with all outputs 0.
- FETCH:
  - Drives `mem_req`=1, `mem_addr_sel`=0.
  - When `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=0, next state DECODE.
  - Otherwise remains in FETCH.
- DECODE: single cycle with no strobes; next state EXEC.
- EXEC:
  - Always drives `alu_opcode`=ALU code of `op_q` and `alu_out_we`=1.
  - ALU ops (4–7): `alu_src_b`=0; next state WB.
  - LW/SW: `alu_src_b`=1; next state MEM.
  - BEQ/BLT: `alu_src_b`=0, `pc_src`=1, `pc_write`=`change_pc`, `instr_done`=1; next state FETCH.
- MEM:
  - Drives `mem_req`=1, `mem_addr_sel`=1, `mem_we`=(`op_q`==SW).
  - Waits for `mem_ready`=1.
  - SW completes with `instr_done`=1 and returns to FETCH.
  - LW goes to WB.
- WB: `reg_write`=1, `wb_sel`=(`op_q`==LW), `instr_done`=1; next state FETCH.
- Output encoding:
  - All strobes and selects are combinational from `state`, `op_q`, `mem_ready` and `change_pc`.
  - Any output not listed for a state is 0.
  - `alu_opcode` is 0 outside EXEC.
- `instr_count` increments by 1 on every edge where `instr_done`=1. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset, while `rst`=1:
  - `state`=FETCH, `op_q`=0, `instr_count`=0.
  - Every combinational output is forced to 0, including `mem_req`.
  - First fetch request appears in the first cycle after `rst` deasserts.
- Memory handshake:
  - `mem_req`, `mem_we` and `mem_addr_sel` stay stable from request until `mem_ready` is sampled high at a rising edge.
  - Transfer completes on that edge.
  - `mem_ready` already high in the first request cycle gives a zero-wait access.
- Latency with zero-wait memory, cycles from FETCH entry to the next FETCH entry:
  - ALU op: 4.
  - LW: 5.
  - SW: 4.
  - BEQ/BLT: 3.
  - Each wait cycle (`mem_ready`=0 while requested) adds 1.
- `instr_done` is asserted in the final cycle of each instruction, coincident with that cycle's write strobe if any.
- `change_pc` is used only in EXEC for a branch `op_q`. It is ignored in every other state.
- Reset asserted mid-instruction (any state):
  - Outputs go to 0 immediately (asynchronous); no pending write completes.
  - `instr_count` clears.
  - After release, the FSM restarts at FETCH.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `mem_ready`=1 → all outputs 0, `state`=0, `instr_count`=0. First cycle after release shows `mem_req`=1, `mem_addr_sel`=0.
- ADD, `instr[31:29]`=4, `mem_ready`=1 → states 0,1,2,4. EXEC shows `alu_opcode`=4, `alu_out_we`=1. WB shows `reg_write`=1, `wb_sel`=0, `instr_done`=1. `instr_count`=1.
- LW, `instr[31:29]`=0, 2 wait cycles in MEM → EXEC has `alu_opcode`=4, `alu_src_b`=1. MEM holds `mem_req`=1, `mem_addr_sel`=1, `mem_we`=0 for 3 cycles. WB has `wb_sel`=1. Total 7 cycles.
- SW then OR → SW MEM cycle has `mem_we`=1 and `instr_done`=1 with no WB state. OR EXEC has `alu_opcode`=7. `instr_count` reaches 2.
- BEQ with `change_pc`=1, then BLT with `change_pc`=0 → BEQ EXEC shows `alu_opcode`=2, `pc_write`=1, `pc_src`=1. BLT EXEC shows `alu_opcode`=3, `pc_write`=0. Each instruction takes 3 cycles.
- Reset during an LW MEM wait → `mem_req` drops in the same cycle and no `reg_write` occurs. After release, `state`=FETCH and `instr_count`=0.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
//
// Multi-cycle control FSM for a datapath with one shared 32-bit ALU and one
// unified memory port. Each instruction steps through FETCH, DECODE, EXEC,
// then MEM and/or WB as its major opcode requires. The FSM drives the ALU
// opcode, all datapath write strobes and mux selects, and resolves branches
// from the ALU change_pc flag.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   instr        in   memory read data; bits [31:29] hold the major opcode
//   mem_ready    in   memory acknowledge, only meaningful while mem_req=1
//   change_pc    in   ALU branch-taken flag, used in EXEC for branches
//   mem_req      out  memory access request
//   mem_we       out  memory write enable (qualifies mem_req)
//   mem_addr_sel out  address mux: 0=PC, 1=ALUOut
//   ir_write     out  load IR from memory data
//   pc_write     out  PC load enable
//   pc_src       out  PC source: 0=PC+1, 1=branch target
//   alu_opcode   out  ALU operation code (0 outside EXEC)
//   alu_src_b    out  ALU B input: 0=register, 1=sign-extended immediate
//   alu_out_we   out  latch ALU result into ALUOut
//   reg_write    out  register-file write enable
//   wb_sel       out  write-back source: 0=ALUOut, 1=memory data
//   instr_done   out  one-cycle retirement pulse
//   state        out  current FSM state (debug)
//   instr_count  out  number of retired instructions (wraps)
// -----------------------------------------------------------------------------
module alu_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        change_pc,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic [2:0]  alu_opcode,
    output logic        alu_src_b,
    output logic        alu_out_we,
    output logic        reg_write,
    output logic        wb_sel,
    output logic        instr_done,
    output logic [2:0]  state,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_SW  = 3'd1;
    localparam logic [2:0] OP_BEQ = 3'd2;
    localparam logic [2:0] OP_BLT = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_op_q;
    logic [31:0] r_instr_count;

    logic        w_is_branch;
    logic        w_is_mem_op;
    logic [2:0]  w_alu_code;

    assign w_is_branch = (r_op_q == OP_BEQ) || (r_op_q == OP_BLT);
    assign w_is_mem_op = (r_op_q == OP_LW)  || (r_op_q == OP_SW);
    // Loads and stores borrow ADD for address generation.
    assign w_alu_code  = w_is_mem_op ? OP_ADD : r_op_q;

    // -------------------------------------------------------------------------
    // State, opcode and retirement-counter registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_FETCH;
            r_op_q        <= 3'd0;
            r_instr_count <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (ir_write)
                r_op_q <= instr[31:29];
            if (instr_done)
                r_instr_count <= r_instr_count + 32'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        alu_opcode   = 3'd0;
        alu_src_b    = 1'b0;
        alu_out_we   = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = 1'b0;
        instr_done   = 1'b0;

        // Outputs are gated by rst so an asserted reset silences every strobe
        // immediately, before the asynchronous register reset is even seen.
        if (!rst) begin
            unique case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write     = 1'b1;
                        pc_write     = 1'b1;
                        w_next_state = S_DECODE;
                    end
                end

                S_DECODE: begin
                    w_next_state = S_EXEC;
                end

                S_EXEC: begin
                    alu_opcode = w_alu_code;
                    alu_out_we = 1'b1;
                    if (w_is_branch) begin
                        pc_src       = 1'b1;
                        pc_write     = change_pc;
                        instr_done   = 1'b1;
                        w_next_state = S_FETCH;
                    end else if (w_is_mem_op) begin
                        alu_src_b    = 1'b1;
                        w_next_state = S_MEM;
                    end else begin
                        w_next_state = S_WB;
                    end
                end

                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (r_op_q == OP_SW);
                    if (mem_ready) begin
                        if (r_op_q == OP_SW) begin
                            instr_done   = 1'b1;
                            w_next_state = S_FETCH;
                        end else begin
                            w_next_state = S_WB;
                        end
                    end
                end

                S_WB: begin
                    reg_write    = 1'b1;
                    wb_sel       = (r_op_q == OP_LW);
                    instr_done   = 1'b1;
                    w_next_state = S_FETCH;
                end

                // Encodings 5-7 are unreachable; recover to FETCH silently.
                default: begin
                    w_next_state = S_FETCH;
                end
            endcase
        end
    end

    assign state       = r_state;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_ctrl
//
// Self-checking bench for alu_seq_ctrl. Each instruction is described at the
// instruction level (opcode, fetch wait cycles, memory wait cycles, branch
// flag) and expanded into the list of cycles it must occupy and the outputs
// each cycle must show. The bench drives those cycles and compares the DUT
// against the list every cycle, alongside a retired-instruction count.
// -----------------------------------------------------------------------------
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ready;
    logic        change_pc;
    logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src;
    logic [2:0]  alu_opcode;
    logic        alu_src_b, alu_out_we, reg_write, wb_sel, instr_done;
    logic [2:0]  state;
    logic [31:0] instr_count;

    alu_seq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .mem_ready    (mem_ready),
        .change_pc    (change_pc),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .alu_opcode   (alu_opcode),
        .alu_src_b    (alu_src_b),
        .alu_out_we   (alu_out_we),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .instr_done   (instr_done),
        .state        (state),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic [2:0] alu_opcode;
        logic       alu_src_b;
        logic       alu_out_we;
        logic       reg_write;
        logic       wb_sel;
        logic       instr_done;
        logic [2:0] state;
    } outs_t;

    typedef struct packed {
        outs_t      o;
        logic [2:0] op_in;
        logic       rdy;
        logic       cp;
    } cyc_t;

    int          tests  = 0;
    int          fails  = 0;
    logic [31:0] exp_count = 32'd0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic outs_t dut_outs();
        outs_t o;
        o = '{mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
              alu_opcode, alu_src_b, alu_out_we, reg_write, wb_sel,
              instr_done, state};
        return o;
    endfunction

    // Reset: assert asynchronously, hold for n cycles, release after an edge.
    task automatic do_reset(input int n);
        rst = 1'b1;
        #1;
        check("rst_async_outs", 32'(dut_outs()), 32'd0);
        check("rst_async_count", instr_count, 32'd0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_hold_outs", 32'(dut_outs()), 32'd0);
            check("rst_hold_count", instr_count, 32'd0);
            @(posedge clk);
            #1;
        end
        rst       = 1'b0;
        exp_count = 32'd0;
    endtask

    // Expand one instruction into its expected cycle list, drive it, and
    // compare every cycle. abort_at >= 0 asserts reset during that cycle.
    task automatic run_instr(input logic [2:0] op, input int fw, input int mw,
                             input logic cp, input int abort_at, output int ncyc);
        cyc_t q[$];
        cyc_t c;
        logic [31:0] r;
        logic is_mem, is_branch;
        is_mem    = (op == 3'd0) || (op == 3'd1);
        is_branch = (op == 3'd2) || (op == 3'd3);

        for (int k = 0; k < fw; k++) begin
            c = '0; c.o.mem_req = 1; c.o.state = 3'd0;
            c.op_in = 3'($urandom_range(0, 7)); c.rdy = 0; c.cp = 1'($urandom);
            q.push_back(c);
        end
        c = '0; c.o.mem_req = 1; c.o.ir_write = 1; c.o.pc_write = 1; c.o.state = 3'd0;
        c.op_in = op; c.rdy = 1; c.cp = 1'($urandom);
        q.push_back(c);

        c = '0; c.o.state = 3'd1;
        c.op_in = 3'($urandom_range(0, 7)); c.rdy = 1'($urandom); c.cp = 1'($urandom);
        q.push_back(c);

        c = '0; c.o.state = 3'd2; c.o.alu_out_we = 1;
        c.o.alu_opcode = is_mem ? 3'd4 : op;
        c.op_in = 3'($urandom_range(0, 7)); c.rdy = 1'($urandom); c.cp = 1'($urandom);
        if (is_mem) c.o.alu_src_b = 1;
        if (is_branch) begin
            c.cp = cp; c.o.pc_src = 1; c.o.pc_write = cp; c.o.instr_done = 1;
        end
        q.push_back(c);

        if (is_mem) begin
            for (int k = 0; k <= mw; k++) begin
                c = '0; c.o.state = 3'd3; c.o.mem_req = 1; c.o.mem_addr_sel = 1;
                c.o.mem_we = (op == 3'd1);
                c.op_in = 3'($urandom_range(0, 7)); c.cp = 1'($urandom);
                c.rdy = (k == mw);
                c.o.instr_done = (k == mw) && (op == 3'd1);
                q.push_back(c);
            end
        end

        if (!is_branch && op != 3'd1) begin
            c = '0; c.o.state = 3'd4; c.o.reg_write = 1; c.o.wb_sel = (op == 3'd0);
            c.o.instr_done = 1;
            c.op_in = 3'($urandom_range(0, 7)); c.rdy = 1'($urandom); c.cp = 1'($urandom);
            q.push_back(c);
        end

        ncyc = 0;
        foreach (q[i]) begin
            r         = $urandom();
            instr     = {q[i].op_in, r[28:0]};
            mem_ready = q[i].rdy;
            change_pc = q[i].cp;
            if (i == abort_at) begin
                #2;
                check("abort_pre_mem_req", 32'(mem_req), 32'(q[i].o.mem_req));
                do_reset(2);
                return;
            end
            @(negedge clk);
            check("cycle_outs", 32'(dut_outs()), 32'(q[i].o));
            check("cycle_count", instr_count, exp_count);
            @(posedge clk);
            #1;
            if (q[i].o.instr_done) exp_count++;
            ncyc++;
        end
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        instr     = $urandom();
        mem_ready = 1'b1;
        change_pc = 1'b0;

        do_reset(3);

        // ADD, zero-wait
        run_instr(3'd4, 0, 0, 1'b0, -1, n);
        check("add_cycles", n, 4);
        check("add_count", instr_count, 32'd1);

        // LW with 2 memory wait cycles
        run_instr(3'd0, 0, 2, 1'b0, -1, n);
        check("lw_wait_cycles", n, 7);

        // SW then OR
        run_instr(3'd1, 0, 0, 1'b0, -1, n);
        check("sw_cycles", n, 4);
        run_instr(3'd7, 0, 0, 1'b0, -1, n);
        check("or_cycles", n, 4);
        check("after_or_count", instr_count, 32'd4);

        // Branches
        run_instr(3'd2, 0, 0, 1'b1, -1, n);
        check("beq_cycles", n, 3);
        run_instr(3'd3, 0, 0, 1'b0, -1, n);
        check("blt_cycles", n, 3);

        // Fetch waits add a cycle each
        run_instr(3'd5, 2, 0, 1'b0, -1, n);
        check("sub_fwait_cycles", n, 6);

        // Reset during an LW memory wait (index 5 = second MEM wait cycle)
        run_instr(3'd0, 1, 3, 1'b0, 5, n);
        check("abort_count", instr_count, 32'd0);
        check("abort_state", 32'(state), 32'd0);
        run_instr(3'd6, 0, 0, 1'b0, -1, n);
        check("post_abort_cycles", n, 4);
        check("post_abort_count", instr_count, 32'd1);

        // Randomized instruction stream
        for (int t = 0; t < 300; t++) begin
            logic [2:0] op;
            int fw, mw, want;
            op = 3'($urandom_range(0, 7));
            fw = $urandom_range(0, 2);
            mw = $urandom_range(0, 2);
            run_instr(op, fw, mw, 1'($urandom), -1, n);
            case (op)
                3'd0:       want = 5 + fw + mw;
                3'd1:       want = 4 + fw + mw;
                3'd2, 3'd3: want = 3 + fw;
                default:    want = 4 + fw;
            endcase
            check("rand_cycles", n, want);
        end
        @(negedge clk);
        check("final_count", instr_count, exp_count);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
